// File: rtl/ram_pkg.sv
// Shared constants for the sequential RAM read engine: default widths,
// FSM encoding and the skid buffer depth used for read credit accounting.
package ram_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int SKID_DEPTH = 2;

   // A new read may launch only if every word already owed to the stream
   // (buffered or still in the RAM pipeline) fits, counting this cycle's pop.
   function automatic logic has_credit(input logic [2:0] occupied, input logic pop);
      return occupied < (3'(SKID_DEPTH) + {2'b00, pop});
   endfunction

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry first-word-fall-through buffer between the RAM read data and the
// output stream; head word is always presented on o_data.
module ram_rd_skid
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_head;
   logic [DATA_W-1:0] r_tail;
   logic [1:0]        r_count;
   logic              w_pop;

   assign w_pop = i_pop & (r_count != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({i_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_push_data;
               else                 r_tail <= i_push_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; the new word lands behind whatever remains.
               if (r_count == 2'd1) begin
                  r_head <= i_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data  = r_head;
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/ram_seq_reader.sv
// Sequential read engine: reads start_addr .. start_addr+len-1 (wrapping) from
// a 1-cycle-latency RAM and streams the words out with valid/ready.
module ram_seq_reader
   import ram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_addr_ctr;
   logic [ADDR_W-1:0] r_read_addr;
   logic [ADDR_W:0]   r_issue_left;
   logic [ADDR_W:0]   r_beats_left;
   logic [1:0]        r_inflight;   // [0] address at RAM port, [1] word on ram_q
   logic              r_busy;
   logic              r_done;

   logic              w_accept;
   logic              w_first_issue;
   logic              w_issue;
   logic              w_pop;
   logic [1:0]        w_count;
   logic [2:0]        w_occupied;

   assign w_accept      = (r_state == ST_IDLE) && start && !r_busy;
   assign w_first_issue = w_accept && (len != '0);
   assign w_pop         = out_valid & out_ready;
   assign w_occupied    = {1'b0, w_count} + {2'b00, r_inflight[0]} + {2'b00, r_inflight[1]};
   assign w_issue       = (r_state == ST_RUN) && (r_issue_left != '0)
                          && has_credit(w_occupied, w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_addr_ctr   <= '0;
         r_read_addr  <= '0;
         r_issue_left <= '0;
         r_beats_left <= '0;
         r_inflight   <= 2'b00;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= {r_inflight[0], w_first_issue | w_issue};
         if (r_done)
            r_busy <= 1'b0;
         if (w_pop && (r_beats_left != '0))
            r_beats_left <= r_beats_left - 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_busy <= 1'b1;
                  if (len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     // The first read launches on the accept edge itself.
                     r_read_addr  <= start_addr;
                     r_addr_ctr   <= start_addr + 1'b1;
                     r_issue_left <= len - 1'b1;
                     r_beats_left <= len;
                     r_state      <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_issue) begin
                  r_read_addr  <= r_addr_ctr;
                  r_addr_ctr   <= r_addr_ctr + 1'b1;
                  r_issue_left <= r_issue_left - 1'b1;
               end
               if (r_issue_left == '0)
                  r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_pop && (r_beats_left == 1)) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   ram_rd_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .i_push      (r_inflight[1]),
      .i_push_data (ram_q),
      .i_pop       (w_pop),
      .o_data      (out_data),
      .o_valid     (out_valid),
      .o_count     (w_count)
   );

   assign busy      = r_busy;
   assign done      = r_done;
   assign read_addr = r_read_addr;
   assign out_last  = out_valid & (r_beats_left == 1);

endmodule
